bcd_countdown: RTL
==================

# bcd_countdown

Synchronous BCD countdown timer for the DE1-SoC lab top level: the decrementing counterpart of the ripple up-counter. It loads a start value from switches, counts down once per internal prescaler tick, and supports start/pause from push-button-derived levels. On reaching zero it raises a sticky `done`. Each BCD digit drives a HEX display through an active-low 7-segment decoder.

## Interface
- `DIGITS`, default 2: number of BCD digits (1–6).
- `TICK_W`, default 25: prescaler width. One tick every 2^TICK_W `clk` cycles while running (25 gives about 0.67 s at 50 MHz).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  level. While high: count ← `load_val` and state → IDLE.
- `load_val`  in  4*DIGITS  BCD start value; digit 0 is in the LSBs.
- `start`  in  1  level, already synchronized to `clk`; acts on its rising edge.
- `pause`  in  1  level, already synchronized to `clk`; acts on its rising edge.
- `count`  out  4*DIGITS  current BCD value (registered).
- `running`  out  1  high exactly while in state RUN (registered).
- `done`  out  1  sticky terminal flag (registered).
- `hex`  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit 0 is in the LSBs.

## Operation
- States are IDLE, RUN, PAUSE and DONE. `running` = (state==RUN). `done` = (state==DONE).
- Reset values: state IDLE, `count` 0, prescaler 0, `running` 0, `done` 0, both edge-detect registers 1. Each `hex` digit shows "0" (7'b1000000).
- Edge detection: `start_e` = `start` & ~`start_q`; likewise `pause_e`. The `_q` registers reset to 1, so a level held through reset gives no edge.
- Priority is reset > load > state transitions.
- Load (any state): `count` ← `load_val`. Any digit above 9 is clamped to 9. Prescaler ← 0, state ← IDLE, `done` ← 0.
- IDLE, `start_e`: if `count` ≠ 0, go to RUN; otherwise go to DONE. `pause_e` is ignored.
- RUN:
  - Prescaler increments every cycle.
  - Tick = prescaler all-ones. On a tick, `count` decrements in BCD: a digit at 0 becomes 9 and borrows from the next digit.
  - If a tick takes `count` from 1 to 0, go to DONE.
  - `pause_e`: go to PAUSE. If `pause_e` and a tick occur in the same cycle, the decrement still applies.
  - `start_e` is ignored.
- PAUSE: prescaler and `count` hold. `start_e` resumes RUN with the prescaler continuing from its held value. `pause_e` is ignored.
- DONE: `count` holds at 0. `start_e` and `pause_e` are ignored. Only `load` or `reset` leaves DONE.
- `hex` is purely combinational from `count`; it is never blank.

## Timing
- A `start_e` sampled at edge N makes state RUN after edge N (1-cycle latency). The same applies to `pause_e` and to load.
- First decrement occurs at edge N + 2^TICK_W. After that, one decrement every 2^TICK_W cycles, excluding cycles spent in PAUSE.
- From start to `done`: exactly V·2^TICK_W cycles, where V is the loaded value. `running` falls and `done` rises on the same edge that `count` reaches 0.
- Reset or load mid-run takes effect at the next edge and leaves no residual prescaler phase.

## Structure
- Package `bcd_countdown_pkg`:
  - state enum typedef
  - 7-segment constants for digits 0–9
  - function `bcd_clamp` (per-digit clamp to 9)
  - function `bcd_dec` (multi-digit BCD decrement with borrow)
- Sub-module `seg7_decoder`: 4-bit BCD in, 7-bit active-low segments out. It is instantiated DIGITS times via generate.
- The prescaler, edge detectors and FSM live in `bcd_countdown`.

## Test plan
All scenarios use DIGITS=2 and TICK_W=2.
- Reset pulse → `count` 8'h00, `running` 0, `done` 0, `hex` 14'b1000000_1000000.
- Load 8'h12, then `start` pulse at edge N → `running` 1 after N; `count` 8'h11 at N+4, 8'h10 at N+8, 8'h09 at N+12 (borrow); `count` 8'h00 with `done` 1 and `running` 0 at N+48.
- Load 8'hF3 → `count` 8'h93. `hex` digit1 = 7'b0010000 (9), digit0 = 7'b0110000 (3).
- Run with load 8'h05, `pause` edge after 6 cycles, hold 20 cycles, then `start` edge → `count` frozen during PAUSE; `done` exactly 20 cycles later than the unpaused case.
- `start` edge with `count` 8'h00 → DONE after 1 edge, `running` never asserted. A further `start` edge → no change.
- `load` of 8'h07 during RUN → IDLE, `count` 8'h07, `done` 0, no decrement until a new `start`. `reset` mid-run with `start` held high → reset values, and no RUN entry until `start` goes low and high again.

Source files
------------

// File: rtl/bcd_countdown_pkg.sv
// Shared types, 7-segment glyphs and BCD helper functions for the BCD countdown timer.
// Helpers work on the widest supported count (6 digits); callers zero-extend and truncate.
package bcd_countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  localparam int MAX_DIGITS = 6;
  localparam int BCD_MAX_W  = 4 * MAX_DIGITS;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic logic [BCD_MAX_W-1:0] bcd_clamp(input logic [BCD_MAX_W-1:0] v);
    logic [BCD_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [BCD_MAX_W-1:0] bcd_dec(input logic [BCD_MAX_W-1:0] v);
    logic [BCD_MAX_W-1:0] r;
    logic                 borrow;
    r      = '0;
    borrow = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (!borrow) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown_if.sv
// Control/status bundle of the BCD countdown timer; master drives controls, slave is the timer.
interface bcd_countdown_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  pause;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  done;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output load, load_val, start, pause,
    input  count, running, done, hex
  );

  modport slave (
    input  load, load_val, start, pause,
    output count, running, done, hex
  );
endinterface

// File: rtl/bcd_countdown_seg7_decoder.sv
// One BCD digit to active-low 7-segment pattern; out-of-range codes show "0" so the display is never blank.
module seg7_decoder
  import bcd_countdown_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (bcd)
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/bcd_countdown.sv
// BCD countdown timer: load/start/pause control, prescaled BCD decrement and sticky done flag.
module bcd_countdown
  import bcd_countdown_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int TICK_W = 25
) (
  input  logic            clk,
  input  logic            reset,
  bcd_countdown_if.slave  bus
);

  localparam int CW = 4 * DIGITS;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic                start_q, pause_q;
  logic                start_e, pause_e;
  logic                tick;
  logic [BCD_MAX_W-1:0] clamp_full, dec_full;
  logic                dec_zero;
  logic                unused_hi;
  logic [7*DIGITS-1:0] hex_w;

  assign start_e = bus.start & ~start_q;
  assign pause_e = bus.pause & ~pause_q;
  assign tick    = &presc_q;

  assign clamp_full = bcd_clamp(BCD_MAX_W'(bus.load_val));
  assign dec_full   = bcd_dec(BCD_MAX_W'(count_q));
  assign dec_zero   = (dec_full == '0);
  // Only the low CW bits of the wide helpers are meaningful for this digit count
  assign unused_hi  = ^{clamp_full, dec_full};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    if (bus.load) begin
      count_d = clamp_full[CW-1:0];
      presc_d = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_e) state_d = (count_q != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: begin
          presc_d = presc_q + 1'b1;
          if (tick) count_d = dec_full[CW-1:0];
          // Reaching zero wins over a simultaneous pause
          if (tick && dec_zero) state_d = ST_DONE;
          else if (pause_e)     state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start_e) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      start_q <= 1'b1;
      pause_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      start_q <= bus.start;
      pause_q <= bus.pause;
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_decoder u_seg (
      .bcd (count_q[4*g +: 4]),
      .seg (hex_w[7*g +: 7])
    );
  end

  assign bus.hex = hex_w;

endmodule
